pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath; next generation
//  of the 64-bit combinational adder. Splits the carry chain into STAGES registered slices,
//  adds a subtract mode and Y86 condition flags (ZF/SF/OF), and moves operands and results
//  through valid/ready handshakes so the execute stage can issue one operation per cycle.
// PARAMETERS
//  WIDTH   64  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = latency in cycles; 1..WIDTH; slice width CW = WIDTH/STAGES
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      reset; synchronous, active-low
//  in_valid   in   1      a, b, op hold an operation
//  in_ready   out  1      block accepts an operation this cycle
//  a          in   WIDTH  operand A (signed)
//  b          in   WIDTH  operand B (signed)
//  op         in   1      0: a+b   1: a-b (a + ~b + 1)
//  out_valid  out  1      sum and flags hold a result
//  out_ready  in   1      consumer takes the result this cycle
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  carry      out  1      carry out of the MSB (for subtract: 1 = no borrow)
//  overflow   out  1      signed overflow (OF)
//  zero       out  1      sum == 0 (ZF)
//  sign       out  1      sum[WIDTH-1] (SF)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all stage valid bits clear; out_valid=0, sum=0, carry=0,
//    overflow=0, zero=0, sign=0. Ops in flight are dropped, not completed. in_ready=1 in reset.
//  - Transfer rules: input accepted on an edge with in_valid & in_ready; output consumed on an
//    edge with out_valid & out_ready. in_valid and its operands stay stable until accepted.
//  - Stall: stall = out_valid & ~out_ready; in_ready = ~stall. On stall every stage register,
//    output included, holds. With no stall the pipe advances one stage per cycle; bubbles
//    (valid=0) advance like data. Back-to-back ops at 1 per cycle when out_ready is held high.
//  - Latency: an op accepted at edge N appears on outputs after edge N+STAGES-1 (out_valid high
//    in the cycle after that edge) with no stalls. Results leave in issue order; none lost or duplicated.
//  - Stage k (0..STAGES-1) adds slice [k*CW +: CW] of a and (op ? ~b : b) with the carry from
//    stage k-1 (stage 0 carry-in = op). It registers the partial sum and carry-out. Upper operand
//    slices and op are delayed alongside so each slice is added in its own stage.
//  - Flags are computed from the completed WIDTH-bit result in the last stage:
//    overflow = (A[msb]==B'[msb]) & (sum[msb]!=A[msb]), where B' = op ? ~b : b;
//    zero = ~|sum; sign = sum[WIDTH-1]; carry = last stage carry-out.
//  - Outputs are registered only; no combinational path from a/b to sum. in_ready depends only on
//    out_valid and out_ready.
//  - STAGES=1: one full-width registered add; latency 1.
//  - If the input is stalled while out_ready rises in the same cycle, the op is accepted on that edge.
//  - Reset asserted mid-stall: the held result is discarded and out_valid=0 on the next cycle.
// TESTING
//  1 add, a=b=64'hFFFF_FFFF_FFFF_FFFF -> sum=64'hFFFF_FFFF_FFFF_FFFE, carry=1, OF=0, SF=1, ZF=0,
//    after exactly 4 cycles
//  2 add, a=b=64'h7FFF_FFFF_FFFF_FFFF -> sum=64'hFFFF_FFFF_FFFF_FFFE, OF=1, SF=1, carry=0;
//    a=b=64'h8000_0000_0000_0001 -> sum=64'h2, carry=1, OF=1, SF=0
//  3 sub, a=b=5 -> sum=0, ZF=1, carry=1, OF=0; sub a=0,b=1 -> sum=all ones, carry=0, SF=1;
//    sub a=64'h8000_0000_0000_0000, b=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, OF=1
//  4 stream 10 random ops at 1/cycle with out_ready=1 -> 10 results in order, each equal to the
//    golden a+b / a-b (65-bit reference) and flags
//  5 issue 6 ops, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall; outputs
//    held stable; all 6 results delivered in order with no loss or duplication
//  6 pull rst_n low for 1 cycle with 3 ops in flight -> out_valid=0 and all outputs 0 next cycle;
//    no stale result emitted; repeat 1-4 with WIDTH=32, STAGES=1 and WIDTH=16, STAGES=16

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The master side issues operations and consumes results.
interface pipelined_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             sign;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum,
    input  carry, overflow, zero, sign
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum,
    output carry, overflow, zero, sign
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub with Y86 flags.
// The carry chain is cut into STAGES registered slices.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  stg_t        q   [STAGES];
  stg_t        d   [STAGES];
  stg_t        src [STAGES];
  logic [CW:0] t   [STAGES];
  logic        of_q, of_d;
  logic        zf_q, zf_d;
  logic        adv;

  assign adv = ~(q[L].v & ~bus.out_ready);
  assign bus.in_ready = adv;

  // b is inverted once at entry; op rides in as the stage-0 carry
  always_comb begin
    src[0].v = bus.in_valid;
    src[0].c = bus.op;
    src[0].a = bus.a;
    src[0].b = bus.op ? ~bus.b : bus.b;
    src[0].s = '0;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = q[k-1];
    end
  end

  always_comb begin
    of_d = 1'b0;
    zf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      t[k] = {1'b0, src[k].a[k*CW +: CW]}
           + {1'b0, src[k].b[k*CW +: CW]}
           + {{CW{1'b0}}, src[k].c};
      d[k]   = src[k];
      d[k].c = t[k][CW];
      d[k].s[k*CW +: CW] = t[k][CW-1:0];
    end
    of_d = (src[L].a[WIDTH-1] == src[L].b[WIDTH-1])
         & (d[L].s[WIDTH-1] != src[L].a[WIDTH-1]);
    zf_d = ~|d[L].s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        q[k] <= '0;
      end
      of_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        q[k] <= d[k];
      end
      of_q <= of_d;
      zf_q <= zf_d;
    end
  end

  assign bus.out_valid = q[L].v;
  assign bus.sum       = q[L].s;
  assign bus.carry     = q[L].c;
  assign bus.overflow  = of_q;
  assign bus.zero      = zf_q;
  assign bus.sign      = q[L].s[WIDTH-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 64/4 main instance plus
// 32/1 and 16/16 instances fed the same operations.
module tb_pipelined_addsub;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv, dop, rdy;
  logic [63:0] da, db;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_n;
  int          ap [3];
  int          rp [3];
  int          wid [3] = '{64, 32, 16};
  int          stg [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(64)) b64 ();
  pipelined_addsub_if #(.WIDTH(32)) b32 ();
  pipelined_addsub_if #(.WIDTH(16)) b16 ();

  assign b64.in_valid = dv;
  assign b64.op = dop;
  assign b64.a = da;
  assign b64.b = db;
  assign b64.out_ready = rdy;
  assign b32.in_valid = dv;
  assign b32.op = dop;
  assign b32.a = da[31:0];
  assign b32.b = db[31:0];
  assign b32.out_ready = 1'b1;
  assign b16.in_valid = dv;
  assign b16.op = dop;
  assign b16.a = da[15:0];
  assign b16.b = db[15:0];
  assign b16.out_ready = 1'b1;

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) u64 (
    .clk(clk), .rst_n(rst_n), .bus(b64.slave));
  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave));
  pipelined_addsub #(.WIDTH(16), .STAGES(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave));

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [63:0] s;
    logic [3:0]  f;
    int          cyc;
  } res_t;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic        c, v, z, n;
  } vec_t;

  acc_t accq [3][$];
  res_t resq [3][$];

  logic [2:0]  o_v, i_r, o_r;
  logic [63:0] o_s [3];
  logic [3:0]  o_f [3];

  assign o_v = {b16.out_valid, b32.out_valid, b64.out_valid};
  assign i_r = {b16.in_ready, b32.in_ready, b64.in_ready};
  assign o_r = {1'b1, 1'b1, rdy};
  assign o_s[0] = b64.sum;
  assign o_s[1] = {32'd0, b32.sum};
  assign o_s[2] = {48'd0, b16.sum};
  assign o_f[0] = {b64.carry, b64.overflow, b64.zero, b64.sign};
  assign o_f[1] = {b32.carry, b32.overflow, b32.zero, b32.sign};
  assign o_f[2] = {b16.carry, b16.overflow, b16.zero, b16.sign};

  // mid-cycle monitor: records the transfers the next edge will make
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (dv && i_r[i])
          accq[i].push_back('{dop, da, db, cyc});
        if (o_v[i] && o_r[i])
          resq[i].push_back('{o_s[i], o_f[i], cyc});
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // golden reference in wide unsigned and signed arithmetic
  function automatic void gold(input int w, input logic op,
      input logic [63:0] a, input logic [63:0] b,
      output logic [63:0] s, output logic c, output logic v,
      output logic z, output logic n);
    logic [63:0]        m, ua, ub;
    logic [64:0]        u;
    logic signed [65:0] sa, sb, sr, lim;
    m  = (64'd1 << w) - 64'd1;
    ua = a & m;
    ub = b & m;
    u  = op ? ({1'b0, ua} - {1'b0, ub}) : ({1'b0, ua} + {1'b0, ub});
    s  = u[63:0] & m;
    c  = op ? (ua >= ub) : u[w];
    sa = $signed({2'b00, ua});
    sb = $signed({2'b00, ub});
    if (ua[w-1]) sa = sa - $signed(66'd1 << w);
    if (ub[w-1]) sb = sb - $signed(66'd1 << w);
    sr  = op ? sa - sb : sa + sb;
    lim = $signed(66'd1 << (w - 1));
    v  = (sr >= lim) || (sr < -lim);
    z  = (s == 64'd0);
    n  = s[w-1];
  endfunction

  task automatic send(input logic op, input logic [63:0] a,
                      input logic [63:0] b);
    logic r;
    int   n;
    dop = op;
    da  = a;
    db  = b;
    dv  = 1'b1;
    n   = 0;
    do begin
      @(negedge clk);
      r = b64.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    last_n = n;
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
  endtask

  task automatic drain();
    dv = 1'b0;
    repeat (25) @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string nm);
    logic [63:0] s;
    logic        c, v, z, n;
    for (int i = 0; i < 3; i++) begin
      while (rp[i] < resq[i].size()) begin
        if (ap[i] >= accq[i].size()) begin
          tests++;
          fails++;
          $display("FAIL %s_extra[%0d]: got %0d results expected %0d",
                   nm, i, resq[i].size(), accq[i].size());
          rp[i] = resq[i].size();
        end else begin
          gold(wid[i], accq[i][ap[i]].op, accq[i][ap[i]].a,
               accq[i][ap[i]].b, s, c, v, z, n);
          chk($sformatf("%s_res[%0d]", nm, i),
              128'({resq[i][rp[i]].s, resq[i][rp[i]].f}),
              128'({s, c, v, z, n}));
          if (i > 0)
            chk($sformatf("%s_lat[%0d]", nm, i),
                128'(resq[i][rp[i]].cyc - accq[i][ap[i]].cyc),
                128'(stg[i]));
          ap[i]++;
          rp[i]++;
        end
      end
      chk($sformatf("%s_count[%0d]", nm, i),
          128'(ap[i]), 128'(accq[i].size()));
    end
  endtask

  vec_t        tbl [10];
  int          n, tot, r0, seen;
  logic [67:0] snap;

  initial begin
    tbl[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
               64'h2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 64'h0001_0000_0000_0000, 64'd1,
               64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
               1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 64'h10, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0,
               1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      ap[i] = 0;
      rp[i] = 0;
    end

    rst_n = 1'b0;
    dv = 1'b0;
    dop = 1'b0;
    da = '0;
    db = '0;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 128'(o_v), 128'(0));
    chk("rst_sum", 128'(b64.sum), 128'(0));
    chk("rst_flags", 128'(o_f[0]), 128'(0));
    chk("rst_ready", 128'(b64.in_ready), 128'(1));

    // directed vectors, one at a time, with exact latency
    for (int k = 0; k < 10; k++) begin
      send(tbl[k].op, tbl[k].a, tbl[k].b);
      dv = 1'b0;
      n = 1;
      while (!b64.out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("vec%0d_lat", k), 128'(n), 128'(4));
      chk($sformatf("vec%0d_sum", k), 128'(b64.sum), 128'(tbl[k].s));
      chk($sformatf("vec%0d_flags", k), 128'(o_f[0]),
          128'({tbl[k].c, tbl[k].v, tbl[k].z, tbl[k].n}));
    end
    drain();
    sb_check("tbl");

    // back-to-back random stream
    tot = 0;
    for (int k = 0; k < 10; k++) begin
      send(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      tot += last_n;
    end
    chk("stream_rate", 128'(tot), 128'(10));
    drain();
    sb_check("stream");

    // consumer stalls for 3 cycles mid-stream
    r0 = resq[0].size();
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(1'(k & 1), {$urandom, $urandom}, {$urandom, $urandom});
        dv = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        rdy = 1'b0;
        snap = {b64.sum, o_f[0]};
        chk("stall_valid", 128'(b64.out_valid), 128'(1));
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk($sformatf("stall_ready%0d", j), 128'(b64.in_ready), 128'(0));
          chk($sformatf("stall_hold%0d", j),
              128'({b64.sum, o_f[0]}), 128'(snap));
          @(posedge clk);
          #1;
        end
        rdy = 1'b1;
      end
    join
    drain();
    chk("stall_count", 128'(resq[0].size() - r0), 128'(6));
    sb_check("stall");

    // reset with three operations in flight
    for (int k = 0; k < 3; k++)
      send(1'b0, 64'(k + 1), 64'd100);
    dv = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_valid", 128'(b64.out_valid), 128'(0));
    chk("mid_rst_out", 128'({b64.sum, o_f[0]}), 128'(0));
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (b64.out_valid) seen++;
    end
    chk("mid_rst_stale", 128'(seen), 128'(0));
    for (int i = 0; i < 3; i++) begin
      ap[i] = accq[i].size();
      rp[i] = resq[i].size();
    end

    send(tbl[5].op, tbl[5].a, tbl[5].b);
    send(tbl[6].op, tbl[6].a, tbl[6].b);
    drain();
    sb_check("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
